// File: rtl/tc_stack_pkg.sv
// rtl/tc_stack_pkg.sv - stack operation encoding and push/pop strobe decode
package tc_stack_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } stack_op_e;

    typedef struct packed {
        stack_op_e op;
        logic      ovf_err;   // push refused because the stack is full
        logic      unf_err;   // pop refused because the stack is empty
    } stack_dec_t;

    // Resolves the raw strobes against the current fill state. A push+pop on
    // an empty stack has nothing to replace, so it degrades to a plain push
    // and still reports the refused pop. A push+pop on a full stack is a
    // replace and never overflows.
    function automatic stack_dec_t stack_decode(
        input logic push,
        input logic pop,
        input logic empty,
        input logic full
    );
        stack_dec_t d;
        d.op      = OP_NOP;
        d.ovf_err = 1'b0;
        d.unf_err = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (full) d.ovf_err = 1'b1;
                else      d.op      = OP_PUSH;
            end
            2'b01: begin
                if (empty) d.unf_err = 1'b1;
                else       d.op      = OP_POP;
            end
            2'b11: begin
                if (empty) begin
                    d.op      = OP_PUSH;
                    d.unf_err = 1'b1;
                end else begin
                    d.op      = OP_REPLACE;
                end
            end
            default: d.op = OP_NOP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tc_stack_ram.sv
// rtl/tc_stack_ram.sv - DEPTH x WIDTH storage, sync write port, async read port
module tc_stack_ram
    import tc_stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,     // write clock
    input  logic             we,      // write enable
    input  logic [AW-1:0]    waddr,   // write address
    input  logic [WIDTH-1:0] wdata,   // write data
    input  logic [AW-1:0]    raddr,   // read address (top of stack)
    output logic [WIDTH-1:0] rdata    // combinational read data
);

    // Contents are deliberately not reset; the occupancy count decides
    // which entries are meaningful.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tc_param_stack.sv
// rtl/tc_param_stack.sv - parametrised LIFO stack with occupancy flags and sticky errors
module tc_param_stack
    import tc_stack_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 256,
    parameter int AFULL_LVL = DEPTH - 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,          // all logic on rising edge
    input  logic             rst,          // synchronous, active-high
    input  logic             push,         // push data_in this cycle
    input  logic             pop,          // pop top entry this cycle
    input  logic             clr_err,      // clear sticky error flags
    input  logic [WIDTH-1:0] data_in,      // push data
    output logic [WIDTH-1:0] data_out,     // registered popped word
    output logic             out_valid,    // one-cycle pulse per accepted pop/replace
    output logic [WIDTH-1:0] top,          // current top entry, 0 when empty
    output logic [CW-1:0]    count,        // occupancy 0..DEPTH
    output logic             empty,        // count == 0
    output logic             full,         // count == DEPTH
    output logic             almost_full,  // count >= AFULL_LVL
    output logic             overflow,     // sticky: push refused while full
    output logic             underflow     // sticky: pop refused while empty
);

    localparam int AW = $clog2(DEPTH);

    stack_dec_t       dec;
    logic [AW-1:0]    top_addr;
    logic [AW-1:0]    wr_addr;
    logic             wr_en;
    logic             take_top;
    logic [WIDTH-1:0] top_word;

    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    assign almost_full = (int'(count) >= AFULL_LVL);

    always_comb begin
        dec = stack_decode(push, pop, empty, full);
    end

    // The pointer is the count itself: pushes land at count, the top lives
    // at count-1. When empty, count-1 would wrap past DEPTH-1 for
    // non-power-of-two depths, so the read address is parked at 0 instead.
    assign top_addr = empty ? '0 : AW'(count - CW'(1));
    assign wr_addr  = (dec.op == OP_REPLACE) ? top_addr : AW'(count);
    assign take_top = (dec.op == OP_POP) || (dec.op == OP_REPLACE);

    // Reset must win over a coincident push, so the write is gated too.
    assign wr_en = !rst && ((dec.op == OP_PUSH) || (dec.op == OP_REPLACE));

    tc_stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (data_in),
        .raddr (top_addr),
        .rdata (top_word)
    );

    assign top = empty ? '0 : top_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out_valid <= take_top;
            // A replace reads the old top before the same edge overwrites it.
            if (take_top) begin
                data_out <= top_word;
            end
            case (dec.op)
                OP_PUSH: count <= count + CW'(1);
                OP_POP:  count <= count - CW'(1);
                default: count <= count;
            endcase
            // A fresh error in the same cycle as clr_err keeps the flag set.
            overflow  <= dec.ovf_err | (overflow  & ~clr_err);
            underflow <= dec.unf_err | (underflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_tc_param_stack.sv
// tb/tb_tc_param_stack.sv - self-checking bench for tc_param_stack
module tb_tc_param_stack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=8, DEPTH=4, AFULL_LVL defaults to 3
    logic       a_rst = 1'b0, a_push = 1'b0, a_pop = 1'b0, a_clr = 1'b0;
    logic [7:0] a_din = '0;
    logic [7:0] a_dout, a_top;
    logic [2:0] a_cnt;
    logic       a_ov, a_empty, a_full, a_af, a_ovf, a_unf;

    tc_param_stack #(.WIDTH(8), .DEPTH(4)) u_a (
        .clk(clk), .rst(a_rst), .push(a_push), .pop(a_pop), .clr_err(a_clr),
        .data_in(a_din), .data_out(a_dout), .out_valid(a_ov), .top(a_top),
        .count(a_cnt), .empty(a_empty), .full(a_full), .almost_full(a_af),
        .overflow(a_ovf), .underflow(a_unf)
    );

    // Instance B: WIDTH=16, DEPTH=5, AFULL_LVL=4
    localparam int BD = 5;
    logic        b_rst = 1'b0, b_push = 1'b0, b_pop = 1'b0, b_clr = 1'b0;
    logic [15:0] b_din = '0;
    logic [15:0] b_dout, b_top;
    logic [2:0]  b_cnt;
    logic        b_ov, b_empty, b_full, b_af, b_ovf, b_unf;

    tc_param_stack #(.WIDTH(16), .DEPTH(BD), .AFULL_LVL(4)) u_b (
        .clk(clk), .rst(b_rst), .push(b_push), .pop(b_pop), .clr_err(b_clr),
        .data_in(b_din), .data_out(b_dout), .out_valid(b_ov), .top(b_top),
        .count(b_cnt), .empty(b_empty), .full(b_full), .almost_full(b_af),
        .overflow(b_ovf), .underflow(b_unf)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ctl = {rst, push, pop, clr}; flg = {full, empty, almost_full, overflow, underflow}
    typedef struct packed {
        logic [3:0] ctl;
        logic [7:0] din;
        logic [7:0] dout;
        logic       ov;
        logic [7:0] top;
        logic [2:0] cnt;
        logic [4:0] flg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] ctl, input logic [7:0] din,
                                input logic [7:0] dout, input logic ov,
                                input logic [7:0] top, input logic [2:0] cnt,
                                input logic [4:0] flg);
        vec_t v;
        v.ctl = ctl; v.din = din; v.dout = dout; v.ov = ov;
        v.top = top; v.cnt = cnt; v.flg = flg;
        return v;
    endfunction

    // Queue-based reference model for instance B
    logic [15:0] mq[$];
    logic [15:0] m_dout = '0;
    logic        m_ov = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

    task automatic model_b(input logic r, input logic pu, input logic po,
                           input logic c, input logic [15:0] d);
        logic e_ovf, e_unf;
        e_ovf = 1'b0;
        e_unf = 1'b0;
        if (r) begin
            mq.delete();
            m_dout = '0;
            m_ov   = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            m_ov = 1'b0;
            if (pu && po) begin
                if (mq.size() == 0) begin
                    mq.push_back(d);
                    e_unf = 1'b1;
                end else begin
                    m_dout = mq[mq.size()-1];
                    m_ov   = 1'b1;
                    mq[mq.size()-1] = d;
                end
            end else if (pu) begin
                if (mq.size() == BD) e_ovf = 1'b1;
                else                 mq.push_back(d);
            end else if (po) begin
                if (mq.size() == 0) e_unf = 1'b1;
                else begin
                    m_dout = mq.pop_back();
                    m_ov   = 1'b1;
                end
            end
            m_ovf = e_ovf | (m_ovf & ~c);
            m_unf = e_unf | (m_unf & ~c);
        end
    endtask

    task automatic step_b(input logic r, input logic pu, input logic po,
                          input logic c, input logic [15:0] d);
        logic [15:0] etop;
        b_rst = r; b_push = pu; b_pop = po; b_clr = c; b_din = d;
        @(posedge clk);
        #1;
        cyc++;
        model_b(r, pu, po, c, d);
        etop = (mq.size() == 0) ? 16'h0 : mq[mq.size()-1];
        check($sformatf("b%0d count", cyc), 32'(b_cnt), 32'(mq.size()));
        check($sformatf("b%0d top", cyc), 32'(b_top), 32'(etop));
        check($sformatf("b%0d out_valid", cyc), 32'(b_ov), 32'(m_ov));
        check($sformatf("b%0d data_out", cyc), 32'(b_dout), 32'(m_dout));
        check($sformatf("b%0d empty", cyc), 32'(b_empty), 32'(mq.size() == 0));
        check($sformatf("b%0d full", cyc), 32'(b_full), 32'(mq.size() == BD));
        check($sformatf("b%0d almost_full", cyc), 32'(b_af), 32'(mq.size() >= 4));
        check($sformatf("b%0d overflow", cyc), 32'(b_ovf), 32'(m_ovf));
        check($sformatf("b%0d underflow", cyc), 32'(b_unf), 32'(m_unf));
    endtask

    initial begin
        // Directed table for instance A (DEPTH=4, almost_full at 3)
        vecs.push_back(mk(4'b1000, 8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 5'b01000)); // reset
        vecs.push_back(mk(4'b0100, 8'h11, 8'h00, 1'b0, 8'h11, 3'd1, 5'b00000));
        vecs.push_back(mk(4'b0100, 8'h22, 8'h00, 1'b0, 8'h22, 3'd2, 5'b00000));
        vecs.push_back(mk(4'b0100, 8'h33, 8'h00, 1'b0, 8'h33, 3'd3, 5'b00100));
        vecs.push_back(mk(4'b0010, 8'h00, 8'h33, 1'b1, 8'h22, 3'd2, 5'b00000)); // pops
        vecs.push_back(mk(4'b0010, 8'h00, 8'h22, 1'b1, 8'h11, 3'd1, 5'b00000));
        vecs.push_back(mk(4'b0010, 8'h00, 8'h11, 1'b1, 8'h00, 3'd0, 5'b01000));
        vecs.push_back(mk(4'b0010, 8'h00, 8'h11, 1'b0, 8'h00, 3'd0, 5'b01001)); // pop empty
        vecs.push_back(mk(4'b0001, 8'h00, 8'h11, 1'b0, 8'h00, 3'd0, 5'b01000)); // clr_err
        vecs.push_back(mk(4'b0100, 8'hA0, 8'h11, 1'b0, 8'hA0, 3'd1, 5'b00000));
        vecs.push_back(mk(4'b0100, 8'hA1, 8'h11, 1'b0, 8'hA1, 3'd2, 5'b00000));
        vecs.push_back(mk(4'b0100, 8'hA2, 8'h11, 1'b0, 8'hA2, 3'd3, 5'b00100));
        vecs.push_back(mk(4'b0100, 8'hA3, 8'h11, 1'b0, 8'hA3, 3'd4, 5'b10100)); // full
        vecs.push_back(mk(4'b0100, 8'hA4, 8'h11, 1'b0, 8'hA3, 3'd4, 5'b10110)); // overflow
        vecs.push_back(mk(4'b0110, 8'h7F, 8'hA3, 1'b1, 8'h7F, 3'd4, 5'b10110)); // replace full
        vecs.push_back(mk(4'b0001, 8'h00, 8'hA3, 1'b0, 8'h7F, 3'd4, 5'b10100)); // clr_err
        vecs.push_back(mk(4'b0101, 8'h99, 8'hA3, 1'b0, 8'h7F, 3'd4, 5'b10110)); // error beats clr
        vecs.push_back(mk(4'b0011, 8'h00, 8'h7F, 1'b1, 8'hA2, 3'd3, 5'b00100));
        vecs.push_back(mk(4'b0010, 8'h00, 8'hA2, 1'b1, 8'hA1, 3'd2, 5'b00000));
        vecs.push_back(mk(4'b0110, 8'h7F, 8'hA1, 1'b1, 8'h7F, 3'd2, 5'b00000)); // replace
        vecs.push_back(mk(4'b0100, 8'hC3, 8'hA1, 1'b0, 8'hC3, 3'd3, 5'b00100));
        vecs.push_back(mk(4'b1000, 8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 5'b01000)); // mid reset
        vecs.push_back(mk(4'b0100, 8'h55, 8'h00, 1'b0, 8'h55, 3'd1, 5'b00000));
        vecs.push_back(mk(4'b0010, 8'h00, 8'h55, 1'b1, 8'h00, 3'd0, 5'b01000));
        vecs.push_back(mk(4'b0110, 8'h66, 8'h55, 1'b0, 8'h66, 3'd1, 5'b00001)); // push+pop empty
        vecs.push_back(mk(4'b1100, 8'h88, 8'h00, 1'b0, 8'h00, 3'd0, 5'b01000)); // rst beats push
        vecs.push_back(mk(4'b0100, 8'h77, 8'h00, 1'b0, 8'h77, 3'd1, 5'b00000));

        for (int i = 0; i < vecs.size(); i++) begin
            {a_rst, a_push, a_pop, a_clr} = vecs[i].ctl;
            a_din = vecs[i].din;
            @(posedge clk);
            #1;
            check($sformatf("a%0d data_out", i), 32'(a_dout), 32'(vecs[i].dout));
            check($sformatf("a%0d out_valid", i), 32'(a_ov), 32'(vecs[i].ov));
            check($sformatf("a%0d top", i), 32'(a_top), 32'(vecs[i].top));
            check($sformatf("a%0d count", i), 32'(a_cnt), 32'(vecs[i].cnt));
            check($sformatf("a%0d flags", i), 32'({a_full, a_empty, a_af, a_ovf, a_unf}),
                  32'(vecs[i].flg));
        end
        {a_rst, a_push, a_pop, a_clr} = 4'b0000;

        // Instance B: almost_full edge at 4 then back to 3
        step_b(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        step_b(1'b0, 1'b1, 1'b0, 1'b0, 16'h1001);
        step_b(1'b0, 1'b1, 1'b0, 1'b0, 16'h1002);
        step_b(1'b0, 1'b1, 1'b0, 1'b0, 16'h1003);
        check("af_below_lvl", 32'(b_af), 32'd0);
        step_b(1'b0, 1'b1, 1'b0, 1'b0, 16'h1004);
        check("af_at_lvl", 32'(b_af), 32'd1);
        step_b(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        check("af_fall", 32'(b_af), 32'd0);
        check("af_fall_pop_word", 32'(b_dout), 32'h1004);

        // Instance B: random mix, push bias alternates to sweep full and empty
        for (int k = 0; k < 10000; k++) begin
            int pp;
            pp = ((k / 400) % 2 == 1) ? 70 : 35;
            step_b($urandom_range(0, 599) == 0,
                   $urandom_range(0, 99) < pp,
                   $urandom_range(0, 99) < (100 - pp),
                   $urandom_range(0, 7) == 0,
                   16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tc_param_stack.md
Name: tc_param_stack

Overview:
Parametrised LIFO stack; next-generation replacement for the fixed 8-bit/256-entry stack in the component library.
- Single clock domain, synchronous reset.
- Adds configurable width and depth, full/empty/almost-full flags, occupancy count, and sticky overflow/underflow errors.
- Supports simultaneous push+pop as an atomic replace-top.
- Sits behind the CPU/datapath as a call or operand stack; driven by decoded push/pop strobes.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 256, number of entries (>=2; need not be a power of two)
AFULL_LVL, DEPTH-1, count at or above which almost_full asserts
CW, $clog2(DEPTH+1), count width (derived, not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
push  input  1  write data_in onto stack this cycle
pop  input  1  remove top entry this cycle
clr_err  input  1  clear sticky error flags
data_in  input  WIDTH  push data
data_out  output  WIDTH  registered popped word
out_valid  output  1  one-cycle pulse, data_out updated by an accepted pop
top  output  WIDTH  current top entry (combinational view), 0 when empty
count  output  CW  current occupancy, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
almost_full  output  1  count>=AFULL_LVL
overflow  output  1  sticky: push refused while full
underflow  output  1  sticky: pop refused while empty

Behaviour:
- Reset (rst=1 at posedge): count=0, data_out=0, out_valid=0, overflow=0, underflow=0. Memory contents are not cleared. top reads 0 because empty.
- rst has priority over every other input. Reset mid-burst discards all entries.
- Storage: DEPTH x WIDTH array. Pointer sp=count. Write address is sp. Top address is sp-1.
- Operation table, evaluated at posedge using pre-edge state:
  - push only, not full: mem[sp]<=data_in; count+1.
  - push only, full: no write; count unchanged; overflow<=1.
  - pop only, not empty: data_out<=mem[sp-1]; out_valid<=1; count-1.
  - pop only, empty: data_out holds; out_valid<=0; underflow<=1.
  - push+pop, not empty (including full): replace. data_out<=old top; out_valid<=1; mem[sp-1]<=data_in; count unchanged; no overflow.
  - push+pop, empty: treated as push; underflow<=1; out_valid<=0.
  - neither: out_valid<=0; state holds.
- Latency: popped word appears on data_out one cycle after the pop edge. Pushed word is visible on top immediately after the push edge.
- out_valid is high for exactly one cycle per accepted pop or replace. Back-to-back pops give consecutive pulses.
- clr_err clears overflow/underflow at the edge. A new error in the same cycle wins (flag stays 1).
- count arithmetic uses CW bits and never wraps: saturation is enforced by the full/empty guards, never by modulo.
- Flags are derived combinationally from the registered count: full, empty, almost_full.

Decomposition:
- Package tc_stack_pkg:
  - stack_op_e enum: OP_NOP, OP_PUSH, OP_POP, OP_REPLACE.
  - decode function (push,pop,empty,full) -> stack_op_e plus error bits.
- Sub-module tc_stack_ram: DEPTH x WIDTH, one synchronous write port, one asynchronous read port at address sp-1. Top level holds the pointer, flags and data_out register.

Test Plan:
- Reset, then push 0x11,0x22,0x33 (WIDTH=8) -> count=3, top=0x33. Three pops -> data_out 0x33,0x22,0x11 on successive cycles, each with a out_valid pulse; empty=1 afterwards.
- DEPTH=4: push 5 words (0xA0..0xA4) -> full=1 after the 4th, 5th ignored, overflow=1, top=0xA3. clr_err -> overflow=0.
- Pop on empty -> underflow=1, out_valid stays 0, data_out unchanged, count=0.
- Stack [0x01,0x02], push 0x7F with pop -> data_out=0x02 with out_valid, top=0x7F, count=2. Repeat while full at DEPTH=4 -> no overflow.
- rst asserted mid-sequence at count=3 -> next cycle count=0, empty=1, top=0, flags 0. Push 0x55 -> top=0x55, no stale data visible.
- WIDTH=16, DEPTH=5, AFULL_LVL=4 -> almost_full rises at count=4 and falls on the pop back to 3. Random push/pop mix checked against a queue model for 10k cycles.
